song_note_reader: RTL and testbench

Consumer end of the current-song selector interface. Takes the 2-bit song `select` and the one-cycle `start` pulse, then walks that song's words in the song ROM. Presents each note for its encoded duration in tempo ticks. Returns the `force_prox` pulse to the selector when the song ends, so the selector advances to the next song automatically.

---
 rtl/player_pkg.sv | 25 ++
 rtl/song_note_reader_if.sv | 26 ++
 rtl/note_timer.sv | 29 ++
 rtl/song_note_reader.sv | 126 ++++++++++++
 tb/tb_song_note_reader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/player_pkg.sv
// Shared constants for the song player: field layout, state codes, widths.
package player_pkg;

   localparam int unsigned SONG_W = 2;
   localparam int unsigned IDX_W  = 8;
   localparam int unsigned NOTE_W = 6;
   localparam int unsigned DUR_W  = 4;
   localparam int unsigned WORD_W = NOTE_W + DUR_W;
   localparam int unsigned ADDR_W = SONG_W + IDX_W;

   // ROM word = {note, dur}, note in the MSBs
   localparam int unsigned DUR_LSB  = 0;
   localparam int unsigned DUR_MSB  = DUR_W - 1;
   localparam int unsigned NOTE_LSB = DUR_W;
   localparam int unsigned NOTE_MSB = WORD_W - 1;

   localparam logic [DUR_W-1:0] END_MARKER = '0;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_PLAY  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/song_note_reader_if.sv
// Selector / tempo / ROM / note-output bundle seen by the song note reader.
interface song_note_reader_if;
   import player_pkg::*;

   logic [SONG_W-1:0] select;
   logic              start;
   logic              tick;
   logic              pause;
   logic [WORD_W-1:0] mem_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [NOTE_W-1:0] note;
   logic              note_valid;
   logic              playing;
   logic              force_prox;

   modport master (
      output select, start, tick, pause, mem_data,
      input  mem_addr, note, note_valid, playing, force_prox
   );

   modport slave (
      input  select, start, tick, pause, mem_data,
      output mem_addr, note, note_valid, playing, force_prox
   );

endinterface

// File: rtl/note_timer.sv
// Loadable down-counter measuring one note's duration in tempo ticks.
module note_timer
   import player_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [DUR_W-1:0] i_load_val,
   input  logic             i_tick,
   input  logic             i_pause,
   output logic             o_last_c
);

   logic [DUR_W-1:0] r_cnt;

   // Load wins; otherwise count down on unpaused ticks, parking at 1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_tick && !i_pause && (r_cnt > DUR_W'(1))) begin
         r_cnt <= r_cnt - DUR_W'(1);
      end
   end

   assign o_last_c = (r_cnt == DUR_W'(1)) && i_tick && !i_pause;

endmodule

// File: rtl/song_note_reader.sv
// Walks the selected song's ROM words and presents each note for its duration.
module song_note_reader
   import player_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   song_note_reader_if.slave  bus
);

   logic [2:0]        r_state,      w_state_nxt;
   logic [SONG_W-1:0] r_song,       w_song_nxt;
   logic [IDX_W-1:0]  r_idx,        w_idx_nxt;
   logic [NOTE_W-1:0] r_note,       w_note_nxt;
   logic              r_note_valid, w_note_valid_nxt;
   logic              r_playing,    w_playing_nxt;
   logic              r_force_prox, w_force_prox_nxt;

   logic              w_timer_load;
   logic              w_timer_tick;
   logic              w_last;
   logic [DUR_W-1:0]  w_dur;
   logic [NOTE_W-1:0] w_note_in;

   assign w_dur        = bus.mem_data[DUR_MSB:DUR_LSB];
   assign w_note_in    = bus.mem_data[NOTE_MSB:NOTE_LSB];
   assign w_timer_tick = bus.tick && (r_state == ST_PLAY);

   note_timer u_note_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_timer_load),
      .i_load_val (w_dur),
      .i_tick     (w_timer_tick),
      .i_pause    (bus.pause),
      .o_last_c   (w_last)
   );

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_song       <= '0;
         r_idx        <= '0;
         r_note       <= '0;
         r_note_valid <= 1'b0;
         r_playing    <= 1'b0;
         r_force_prox <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_song       <= w_song_nxt;
         r_idx        <= w_idx_nxt;
         r_note       <= w_note_nxt;
         r_note_valid <= w_note_valid_nxt;
         r_playing    <= w_playing_nxt;
         r_force_prox <= w_force_prox_nxt;
      end
   end

   // Next-state and next-output decode; start overrides every state
   always_comb begin
      w_state_nxt      = r_state;
      w_song_nxt       = r_song;
      w_idx_nxt        = r_idx;
      w_note_nxt       = r_note;
      w_note_valid_nxt = r_note_valid;
      w_force_prox_nxt = 1'b0;
      w_timer_load     = 1'b0;

      if (bus.start) begin
         w_song_nxt       = bus.select;
         w_idx_nxt        = '0;
         w_note_valid_nxt = 1'b0;
         w_state_nxt      = ST_FETCH;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_IDLE;
            end
            ST_FETCH: begin
               w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
               if (w_dur == END_MARKER) begin
                  w_note_valid_nxt = 1'b0;
                  w_state_nxt      = ST_DONE;
               end else begin
                  w_note_nxt       = w_note_in;
                  w_note_valid_nxt = 1'b1;
                  w_timer_load     = 1'b1;
                  w_state_nxt      = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (w_last) begin
                  // Last slot of the song: end rather than spill into the next song
                  if (r_idx == {IDX_W{1'b1}}) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_idx_nxt        = r_idx + IDX_W'(1);
                     w_note_valid_nxt = 1'b0;
                     w_state_nxt      = ST_FETCH;
                  end
               end
            end
            ST_DONE: begin
               w_force_prox_nxt = 1'b1;
               w_note_valid_nxt = 1'b0;
               w_state_nxt      = ST_IDLE;
            end
            default: begin
               w_note_valid_nxt = 1'b0;
               w_state_nxt      = ST_IDLE;
            end
         endcase
      end

      w_playing_nxt = (w_state_nxt != ST_IDLE);
   end

   assign bus.mem_addr   = {r_song, r_idx};
   assign bus.note       = r_note;
   assign bus.note_valid = r_note_valid;
   assign bus.playing    = r_playing;
   assign bus.force_prox = r_force_prox;

endmodule

// File: tb/tb_song_note_reader.sv
// Self-checking bench for song_note_reader: ROM model, note scoreboard, song vectors.
module tb_song_note_reader;
   import player_pkg::*;

   localparam int unsigned ROM_DEPTH = 1 << ADDR_W;
   localparam int          BUDGET    = 3000;

   logic clk;
   logic reset;
   song_note_reader_if bus ();

   song_note_reader u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data valid one cycle after the address
   logic [WORD_W-1:0] rom [ROM_DEPTH];
   always @(posedge clk) bus.mem_data <= rom[bus.mem_addr];

   typedef struct {
      logic [1:0]       song;
      int               n;
      logic [3:0][5:0]  notes;
      logic [3:0][3:0]  durs;
      int               exp_cycles;   // start edge through the force_prox edge
   } vec_t;

   vec_t             vecs [4];
   logic [NOTE_W-1:0] exp_q [$];
   int               n_vec;
   int               n_miss;
   logic             prev_nv;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle; on each rising note_valid the scoreboard head is compared
   task automatic step();
      @(negedge clk);
      if (bus.note_valid && !prev_nv) begin
         if (exp_q.size() == 0) check("note_unexpected", 32'(bus.note), 32'hFFFF);
         else check("note_code", 32'(bus.note), 32'(exp_q.pop_front()));
      end
      prev_nv = bus.note_valid;
   endtask

   task automatic write_song(input logic [1:0] s, input int n,
                             input logic [3:0][5:0] nt, input logic [3:0][3:0] du);
      for (int i = 0; i < n; i++) rom[{s, IDX_W'(i)}] = {nt[i], du[i]};
      rom[{s, IDX_W'(n)}] = '0;
   endtask

   task automatic pulse_start(input logic [1:0] s);
      bus.select = s;
      bus.start  = 1'b1;
      step();
      bus.start  = 1'b0;
   endtask

   task automatic wait_force(inout int cyc);
      while (!bus.force_prox && cyc < BUDGET) begin
         step();
         cyc++;
      end
   endtask

   task automatic after_force(input string tag);
      step();
      check({tag, "_force_one_cycle"}, 32'(bus.force_prox), 0);
      check({tag, "_playing_low"}, 32'(bus.playing), 0);
      check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      int bad;
      logic [3:0][5:0] nt;
      logic [3:0][3:0] du;

      n_vec = 0; n_miss = 0; prev_nv = 1'b0;
      for (int i = 0; i < int'(ROM_DEPTH); i++) rom[i] = '0;
      reset = 1'b1;
      bus.select = '0; bus.start = 1'b0; bus.tick = 1'b0; bus.pause = 1'b0;

      vecs[0] = '{song: 2'd1, n: 2, notes: {6'd0, 6'd0, 6'd9, 6'd7},
                  durs: {4'd0, 4'd0, 4'd2, 4'd1}, exp_cycles: 11};
      vecs[1] = '{song: 2'd0, n: 3, notes: {6'd0, 6'd3, 6'd2, 6'd1},
                  durs: {4'd0, 4'd15, 4'd1, 4'd4}, exp_cycles: 30};
      vecs[2] = '{song: 2'd2, n: 0, notes: '0, durs: '0, exp_cycles: 4};
      vecs[3] = '{song: 2'd3, n: 1, notes: {6'd0, 6'd0, 6'd0, 6'd63},
                  durs: {4'd0, 4'd0, 4'd0, 4'd2}, exp_cycles: 8};

      // Reset values
      step(); step();
      check("rst_mem_addr", 32'(bus.mem_addr), 0);
      check("rst_note", 32'(bus.note), 0);
      check("rst_note_valid", 32'(bus.note_valid), 0);
      check("rst_playing", 32'(bus.playing), 0);
      check("rst_force_prox", 32'(bus.force_prox), 0);
      reset = 1'b0;
      step();

      // Table-driven songs, tick every cycle
      bus.tick = 1'b1;
      for (int v = 0; v < 4; v++) begin
         write_song(vecs[v].song, vecs[v].n, vecs[v].notes, vecs[v].durs);
         for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].notes[i]);
         pulse_start(vecs[v].song);
         check("vec_playing", 32'(bus.playing), 1);
         cyc = 1;
         wait_force(cyc);
         check("vec_cycles", 32'(cyc), 32'(vecs[v].exp_cycles));
         after_force("vec");
      end

      // Manual ticks: first note latency and exact 3-tick hold
      bus.tick = 1'b0;
      nt = {6'd0, 6'd0, 6'd11, 6'd5};
      du = {4'd0, 4'd0, 4'd1, 4'd3};
      write_song(2'd2, 2, nt, du);
      exp_q.push_back(6'd5); exp_q.push_back(6'd11);
      pulse_start(2'd2);
      check("t1_addr_start", 32'(bus.mem_addr), 32'h200);
      step();
      check("t1_nv_load", 32'(bus.note_valid), 0);
      step();
      check("t1_nv_first", 32'(bus.note_valid), 1);
      for (int t = 0; t < 3; t++) begin
         bus.tick = 1'b1; step(); bus.tick = 1'b0; step();
         if (t < 2) check("t1_held", 32'({bus.note_valid, bus.mem_addr}), 32'h600);
      end
      check("t1_next_addr", 32'(bus.mem_addr), 32'h201);
      check("t1_nv_gap", 32'(bus.note_valid), 0);
      bus.tick = 1'b1;
      cyc = 0;
      wait_force(cyc);
      after_force("t1");

      // Restart mid-PLAY of song 0 note 3 into song 1
      nt = {6'd13, 6'd12, 6'd11, 6'd10};
      du = {4'd2, 4'd2, 4'd2, 4'd2};
      write_song(2'd0, 4, nt, du);
      rom[{2'd0, IDX_W'(4)}] = {6'd14, 4'd2};
      rom[{2'd0, IDX_W'(5)}] = '0;
      for (int i = 0; i < 4; i++) exp_q.push_back(nt[i]);
      exp_q.push_back(6'd7); exp_q.push_back(6'd9);
      pulse_start(2'd0);
      cyc = 0;
      while (!(bus.note_valid && bus.mem_addr == 10'h003) && cyc < BUDGET) begin
         step(); cyc++;
      end
      check("t3_reached_idx3", 32'(cyc < BUDGET), 1);
      pulse_start(2'd1);
      check("t3_nv_cleared", 32'(bus.note_valid), 0);
      check("t3_addr_song1", 32'(bus.mem_addr), 32'h100);
      step();
      step();
      check("t3_song1_note0", 32'({bus.note_valid, bus.note}), 32'h47);
      cyc = 0;
      wait_force(cyc);
      after_force("t3");

      // Pause freezes the duration count
      bus.tick = 1'b0;
      rom[{2'd1, IDX_W'(0)}] = {6'd20, 4'd4};
      rom[{2'd1, IDX_W'(1)}] = '0;
      exp_q.push_back(6'd20);
      pulse_start(2'd1);
      step(); step();
      bus.pause = 1'b1; bus.tick = 1'b1;
      for (int i = 0; i < 5; i++) step();
      check("t4_held_paused", 32'(bus.note_valid), 1);
      bus.pause = 1'b0;
      step(); step(); step();
      check("t4_held_3_ticks", 32'(bus.note_valid), 1);
      step();
      check("t4_end_4th_tick", 32'(bus.note_valid), 0);
      cyc = 0;
      wait_force(cyc);
      after_force("t4");

      // Song 3 fills all 256 slots: ends at idx 255 with no wrap
      for (int i = 0; i < 256; i++) begin
         rom[{2'd3, IDX_W'(i)}] = {NOTE_W'(i), 4'd1};
         exp_q.push_back(NOTE_W'(i));
      end
      bad = 0;
      pulse_start(2'd3);
      cyc = 1;
      while (!bus.force_prox && cyc < BUDGET) begin
         step(); cyc++;
         if (bus.mem_addr[ADDR_W-1 -: SONG_W] != 2'd3) bad++;
      end
      check("t5_addr_in_song3", 32'(bad), 0);
      check("t5_cycles", 32'(cyc), 770);
      check("t5_addr_final", 32'(bus.mem_addr), 32'h3FF);
      after_force("t5");

      // Asynchronous reset between edges
      for (int i = 0; i < 4; i++) exp_q.push_back(nt[i]);
      pulse_start(2'd0);
      cyc = 0;
      while (!bus.note_valid && cyc < BUDGET) begin
         step(); cyc++;
      end
      check("t6_note_sounding", 32'(bus.note_valid), 1);
      #2 reset = 1'b1;
      #1;
      check("t6_async_clear",
            32'({bus.note_valid, bus.playing, bus.force_prox, bus.mem_addr}), 0);
      exp_q.delete();
      prev_nv = 1'b0;
      step(); step();
      reset = 1'b0;
      bus.select = 2'd3;
      step(); step(); step();
      check("t6_stays_idle", 32'({bus.note_valid, bus.playing, bus.mem_addr}), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
